fetch_stage: RTL and testbench
==============================

FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, PC and instruction-address width.
REQ-002 SHALL have parameter INST_W, default 9, instruction word width.
REQ-003 SHALL have parameter RESET_ADDR, default 0, PC value loaded at reset.
REQ-004 SHALL have port clock_i  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port reset_n_i  input  1  reset, asynchronous and active-low.
REQ-006 SHALL have port start_i  input  1  load startadd_i into PC and enter RUN.
REQ-007 SHALL have port startadd_i  input  ADDR_W  start address.
REQ-008 SHALL have port branchb_i  input  1  taken backward branch.
REQ-009 SHALL have port branchf_i  input  1  taken forward branch.
REQ-010 SHALL have port target_i  input  ADDR_W  unsigned PC-relative branch distance, not an absolute address.
REQ-011 SHALL have port stall_i  input  1  hold PC and IF/ID contents.
REQ-012 SHALL have port halt_i  input  1  stop fetching.
REQ-013 SHALL have port rom_addr_o  output  ADDR_W  fetch address to instruction ROM.
REQ-014 SHALL have port rom_data_i  input  INST_W  combinational ROM data for rom_addr_o.
REQ-015 SHALL have port ifid_inst_o  output  INST_W  IF/ID instruction register.
REQ-016 SHALL have port ifid_pc_o  output  ADDR_W  address of ifid_inst_o.
REQ-017 SHALL have port ifid_valid_o  output  1  IF/ID register holds a live instruction.
REQ-018 SHALL have port running_o  output  1  high only in RUN state.

Function
REQ-019 SHALL implement a state machine with states IDLE, RUN and HALT.
REQ-020 SHALL drive rom_addr_o directly from the PC register, with no combinational path from any input.
REQ-021 In IDLE, SHALL hold PC and keep ifid_valid_o=0; start_i -> PC<=startadd_i, state RUN.
REQ-022 In RUN, SHALL apply exactly one action per cycle, first match wins: start_i, halt_i, branch, stall_i, normal.
REQ-023 On start_i in RUN or HALT, SHALL set PC<=startadd_i and ifid_valid_o<=0, with state RUN.
REQ-024 On halt_i in RUN, SHALL hold PC, set ifid_valid_o<=0 and go to HALT; HALT exits only via start_i.
REQ-025 On normal advance, SHALL set ifid_inst_o<=rom_data_i, ifid_pc_o<=PC, ifid_valid_o<=1 and PC<=PC+1, giving one-cycle fetch latency.
REQ-026 A branch SHALL be taken only when ifid_valid_o=1; otherwise branchb_i and branchf_i are ignored.
REQ-027 For branchb_i, SHALL set PC<=ifid_pc_o-target_i.
REQ-028 For branchf_i, SHALL set PC<=ifid_pc_o+target_i.
REQ-029 If branchb_i and branchf_i are both high, SHALL give branchb_i priority.
REQ-030 A taken branch SHALL set ifid_valid_o<=0 to squash the wrong-path fetch, and SHALL override stall_i.
REQ-031 On stall_i without a taken branch, SHALL hold PC, ifid_inst_o, ifid_pc_o and ifid_valid_o.
REQ-032 All PC arithmetic SHALL be modulo 2^ADDR_W: PC=2^ADDR_W-1 advances to 0, and branch sums and differences wrap.
REQ-033 running_o SHALL equal 1 in RUN and 0 in IDLE and HALT.

Reset
REQ-034 On reset_n_i=0, SHALL immediately, without waiting for a clock edge, set state=IDLE, PC=RESET_ADDR, ifid_inst_o=0, ifid_pc_o=0, ifid_valid_o=0 and running_o=0.
REQ-035 Reset asserted mid-RUN SHALL abandon any fetch or branch in progress.
REQ-036 After reset_n_i deasserts, SHALL stay in IDLE until start_i.

Verification
REQ-037 Reset then start_i=1 with startadd_i=8'h10 for one cycle -> rom_addr_o follows 10,11,12; after two more edges ifid_pc_o=10, ifid_valid_o=1 and ifid_inst_o=ROM[10].
REQ-038 With ifid_pc_o=8'h20 and valid, branchf_i=1 and target_i=5 -> next PC=25 and ifid_valid_o=0 for one cycle; repeat with branchb_i=1 -> PC=1B.
REQ-039 With startadd_i=8'hFE in run -> PC sequence FE, FF, 00; with ifid_pc_o=02, branchb_i=1 and target_i=4 -> PC=FE.
REQ-040 With stall_i=1 for 3 cycles -> PC and IF/ID unchanged; with stall_i=1 and branchf_i=1 together -> branch taken.
REQ-041 halt_i=1 at PC=30 -> running_o=0, PC holds 30 and ifid_valid_o=0; branch inputs ignored; start_i with startadd_i=40 resumes at 40.
REQ-042 reset_n_i pulsed low asynchronously mid-RUN -> all outputs reach reset values before the next clock edge, and state is IDLE.

Source files
------------

// File: rtl/fetch_stage.sv
// ============================================================================
// Module      : fetch_stage
// Description : Instruction fetch stage with PC, IF/ID register and a
//               IDLE/RUN/HALT controller; PC-relative branch resolution.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module fetch_stage #(
  parameter int                ADDR_W     = 8,
  parameter int                INST_W     = 9,
  parameter logic [ADDR_W-1:0] RESET_ADDR = '0
) (
  input  logic              clock_i,
  input  logic              reset_n_i,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] startadd_i,
  input  logic              branchb_i,
  input  logic              branchf_i,
  input  logic [ADDR_W-1:0] target_i,
  input  logic              stall_i,
  input  logic              halt_i,
  output logic [ADDR_W-1:0] rom_addr_o,
  input  logic [INST_W-1:0] rom_data_i,
  output logic [INST_W-1:0] ifid_inst_o,
  output logic [ADDR_W-1:0] ifid_pc_o,
  output logic              ifid_valid_o,
  output logic              running_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  state_t              r_state;
  logic [ADDR_W-1:0]   r_pc;
  logic [INST_W-1:0]   r_ifid_inst;
  logic [ADDR_W-1:0]   r_ifid_pc;
  logic                r_ifid_valid;
  logic                r_running;

  // Branches only resolve against a live IF/ID entry; backward wins a tie.
  logic                w_branch_taken;
  logic [ADDR_W-1:0]   w_branch_pc;

  assign w_branch_taken = r_ifid_valid & (branchb_i | branchf_i);
  assign w_branch_pc    = branchb_i ? (r_ifid_pc - target_i) : (r_ifid_pc + target_i);

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_state      <= IDLE;
      r_pc         <= RESET_ADDR;
      r_ifid_inst  <= '0;
      r_ifid_pc    <= '0;
      r_ifid_valid <= 1'b0;
      r_running    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_ifid_valid <= 1'b0;
          if (start_i) begin
            r_pc      <= startadd_i;
            r_state   <= RUN;
            r_running <= 1'b1;
          end
        end
        RUN: begin
          if (start_i) begin
            r_pc         <= startadd_i;
            r_ifid_valid <= 1'b0;
          end else if (halt_i) begin
            r_ifid_valid <= 1'b0;
            r_state      <= HALT;
            r_running    <= 1'b0;
          end else if (w_branch_taken) begin
            r_pc         <= w_branch_pc;
            r_ifid_valid <= 1'b0;
          end else if (!stall_i) begin
            r_ifid_inst  <= rom_data_i;
            r_ifid_pc    <= r_pc;
            r_ifid_valid <= 1'b1;
            r_pc         <= r_pc + 1'b1;
          end
        end
        HALT: begin
          r_ifid_valid <= 1'b0;
          if (start_i) begin
            r_pc      <= startadd_i;
            r_state   <= RUN;
            r_running <= 1'b1;
          end
        end
        default: begin
          r_state      <= IDLE;
          r_ifid_valid <= 1'b0;
          r_running    <= 1'b0;
        end
      endcase
    end
  end

  assign rom_addr_o   = r_pc;
  assign ifid_inst_o  = r_ifid_inst;
  assign ifid_pc_o    = r_ifid_pc;
  assign ifid_valid_o = r_ifid_valid;
  assign running_o    = r_running;

endmodule

`default_nettype wire

// File: tb/tb_fetch_stage.sv
// ============================================================================
// Module      : tb_fetch_stage
// Description : Scoreboard bench for fetch_stage with directed vectors.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_fetch_stage;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [7:0] startadd;
  logic       branchb;
  logic       branchf;
  logic [7:0] target;
  logic       stall;
  logic       halt;
  logic [7:0] rom_addr;
  logic [8:0] rom_data;
  logic [8:0] ifid_inst;
  logic [7:0] ifid_pc;
  logic       ifid_valid;
  logic       running;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic       v;
    logic [7:0] pc;
    logic [7:0] rom;
    logic       run;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  function automatic logic [8:0] rom_f(input logic [7:0] a);
    return {a[0] ^ a[7], a ^ 8'h3C};
  endfunction

  assign rom_data = rom_f(rom_addr);

  fetch_stage dut (
    .clock_i     (clk),
    .reset_n_i   (rst_n),
    .start_i     (start),
    .startadd_i  (startadd),
    .branchb_i   (branchb),
    .branchf_i   (branchf),
    .target_i    (target),
    .stall_i     (stall),
    .halt_i      (halt),
    .rom_addr_o  (rom_addr),
    .rom_data_i  (rom_data),
    .ifid_inst_o (ifid_inst),
    .ifid_pc_o   (ifid_pc),
    .ifid_valid_o(ifid_valid),
    .running_o   (running)
  );

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: one expected record per clock, compared mid-cycle.
  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("ifid_valid", {15'd0, ifid_valid}, {15'd0, e.v});
      chk("rom_addr",   {8'd0, rom_addr},    {8'd0, e.rom});
      chk("running",    {15'd0, running},    {15'd0, e.run});
      if (e.v) begin
        chk("ifid_pc",   {8'd0, ifid_pc},   {8'd0, e.pc});
        chk("ifid_inst", {7'd0, ifid_inst}, {7'd0, rom_f(e.pc)});
      end
    end
  end

  task automatic cyc(input logic s, input logic [7:0] sa, input logic bb, input logic bf,
                     input logic [7:0] tgt, input logic st, input logic h,
                     input logic ev, input logic [7:0] epc, input logic [7:0] erom,
                     input logic erun);
    exp_t e;
    start = s; startadd = sa; branchb = bb; branchf = bf;
    target = tgt; stall = st; halt = h;
    @(posedge clk);
    e.v = ev; e.pc = epc; e.rom = erom; e.run = erun;
    sb.push_back(e);
    #1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_rom_addr"},   {8'd0, rom_addr},   16'h0000);
    chk({tag, "_ifid_valid"}, {15'd0, ifid_valid}, 16'h0000);
    chk({tag, "_running"},    {15'd0, running},    16'h0000);
    chk({tag, "_ifid_inst"},  {7'd0, ifid_inst},  16'h0000);
    chk({tag, "_ifid_pc"},    {8'd0, ifid_pc},    16'h0000);
  endtask

  initial begin
    rst_n = 1'b0;
    start = 0; startadd = 0; branchb = 0; branchf = 0;
    target = 0; stall = 0; halt = 0;
    #3;
    chk_reset_outputs("por");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Idle until start, branch request ignored
    cyc(0, 8'h00, 0, 1, 8'h05, 0, 0, 0, 8'h00, 8'h00, 0);
    cyc(0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 8'h00, 8'h00, 0);

    // Start at 0x10, sequential fetch
    cyc(1, 8'h10, 0, 0, 8'h00, 0, 0, 0, 8'h00, 8'h10, 1);
    cyc(0, 8'h00, 0, 0, 8'h00, 0, 0, 1, 8'h10, 8'h11, 1);
    cyc(0, 8'h00, 0, 0, 8'h00, 0, 0, 1, 8'h11, 8'h12, 1);
    cyc(0, 8'h00, 0, 0, 8'h00, 0, 0, 1, 8'h12, 8'h13, 1);

    // Forward branch from 0x20 by 5
    cyc(1, 8'h20, 0, 0, 8'h00, 0, 0, 0, 8'h00, 8'h20, 1);
    cyc(0, 8'h00, 0, 0, 8'h00, 0, 0, 1, 8'h20, 8'h21, 1);
    cyc(0, 8'h00, 0, 1, 8'h05, 0, 0, 0, 8'h00, 8'h25, 1);
    cyc(0, 8'h00, 0, 0, 8'h00, 0, 0, 1, 8'h25, 8'h26, 1);

    // Backward branch from 0x20 by 5, then both-high and squashed-slot cases
    cyc(1, 8'h20, 0, 0, 8'h00, 0, 0, 0, 8'h00, 8'h20, 1);
    cyc(0, 8'h00, 0, 0, 8'h00, 0, 0, 1, 8'h20, 8'h21, 1);
    cyc(0, 8'h00, 1, 0, 8'h05, 0, 0, 0, 8'h00, 8'h1B, 1);
    cyc(0, 8'h00, 0, 0, 8'h00, 0, 0, 1, 8'h1B, 8'h1C, 1);
    cyc(0, 8'h00, 1, 1, 8'h03, 0, 0, 0, 8'h00, 8'h18, 1);
    cyc(0, 8'h00, 0, 1, 8'h03, 0, 0, 1, 8'h18, 8'h19, 1);

    // PC wrap and wrapping branch arithmetic
    cyc(1, 8'hFE, 0, 0, 8'h00, 0, 0, 0, 8'h00, 8'hFE, 1);
    cyc(0, 8'h00, 0, 0, 8'h00, 0, 0, 1, 8'hFE, 8'hFF, 1);
    cyc(0, 8'h00, 0, 0, 8'h00, 0, 0, 1, 8'hFF, 8'h00, 1);
    cyc(0, 8'h00, 0, 0, 8'h00, 0, 0, 1, 8'h00, 8'h01, 1);
    cyc(0, 8'h00, 0, 0, 8'h00, 0, 0, 1, 8'h01, 8'h02, 1);
    cyc(0, 8'h00, 0, 0, 8'h00, 0, 0, 1, 8'h02, 8'h03, 1);
    cyc(0, 8'h00, 1, 0, 8'h04, 0, 0, 0, 8'h00, 8'hFE, 1);
    cyc(0, 8'h00, 0, 0, 8'h00, 0, 0, 1, 8'hFE, 8'hFF, 1);
    cyc(0, 8'h00, 0, 1, 8'h03, 0, 0, 0, 8'h00, 8'h01, 1);

    // Stall holds; branch overrides stall; stall with empty slot holds
    cyc(0, 8'h00, 0, 0, 8'h00, 0, 0, 1, 8'h01, 8'h02, 1);
    cyc(0, 8'h00, 0, 0, 8'h00, 1, 0, 1, 8'h01, 8'h02, 1);
    cyc(0, 8'h00, 0, 0, 8'h00, 1, 0, 1, 8'h01, 8'h02, 1);
    cyc(0, 8'h00, 0, 0, 8'h00, 1, 0, 1, 8'h01, 8'h02, 1);
    cyc(0, 8'h00, 0, 1, 8'h10, 1, 0, 0, 8'h00, 8'h11, 1);
    cyc(0, 8'h00, 0, 0, 8'h00, 1, 0, 0, 8'h00, 8'h11, 1);
    cyc(0, 8'h00, 0, 0, 8'h00, 0, 0, 1, 8'h11, 8'h12, 1);

    // Halt at PC 0x30, branches ignored, restart at 0x40
    cyc(1, 8'h2F, 0, 0, 8'h00, 0, 0, 0, 8'h00, 8'h2F, 1);
    cyc(0, 8'h00, 0, 0, 8'h00, 0, 0, 1, 8'h2F, 8'h30, 1);
    cyc(0, 8'h00, 0, 0, 8'h00, 0, 1, 0, 8'h00, 8'h30, 0);
    cyc(0, 8'h00, 0, 1, 8'h05, 0, 0, 0, 8'h00, 8'h30, 0);
    cyc(0, 8'h00, 1, 0, 8'h05, 0, 1, 0, 8'h00, 8'h30, 0);
    cyc(0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 8'h00, 8'h30, 0);
    cyc(1, 8'h40, 0, 0, 8'h00, 0, 0, 0, 8'h00, 8'h40, 1);
    cyc(0, 8'h00, 0, 0, 8'h00, 0, 0, 1, 8'h40, 8'h41, 1);

    // Restart while running; start beats halt
    cyc(1, 8'h50, 0, 0, 8'h00, 0, 0, 0, 8'h00, 8'h50, 1);
    cyc(0, 8'h00, 0, 0, 8'h00, 0, 0, 1, 8'h50, 8'h51, 1);
    cyc(1, 8'h60, 0, 0, 8'h00, 0, 1, 0, 8'h00, 8'h60, 1);
    cyc(0, 8'h00, 0, 0, 8'h00, 0, 0, 1, 8'h60, 8'h61, 1);

    // Asynchronous reset mid-run with a branch pending
    branchf = 1'b1; target = 8'h07;
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("async");
    @(posedge clk);
    #1;
    chk_reset_outputs("held");
    @(negedge clk);
    rst_n = 1'b1;
    cyc(0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 8'h00, 8'h00, 0);
    cyc(1, 8'h70, 0, 0, 8'h00, 0, 0, 0, 8'h00, 8'h70, 1);
    cyc(0, 8'h00, 0, 0, 8'h00, 0, 0, 1, 8'h70, 8'h71, 1);

    for (int i = 0; i < 4 && sb.size() > 0; i++) @(negedge clk);
    #1;
    chk("sb_drained", 16'(sb.size()), 16'h0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
